// File: rtl/oddr_pkg.sv
// Shared types, PRBS7 taps and two-bit step helper for the ODDR pattern generator.
// The loopback checker (ODDR_PAT_LOOPBACK_CHK_EN) also uses lb_tap_t from here.
package oddr_pkg;

    typedef enum logic [1:0] {
        CLOCK  = 2'd0,
        TOGGLE = 2'd1,
        PRBS7  = 2'd2,
        HOLD   = 2'd3
    } pat_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        RUN  = 2'd2,
        POST = 2'd3
    } gen_state_e;

    // x^7 + x^6 + 1: feedback taps on register bits 6 and 5
    localparam int PRBS7_TAP_HI = 6;
    localparam int PRBS7_TAP_LO = 5;

    typedef struct packed {
        logic [6:0] state;
        logic       early;
        logic       late;
    } prbs_step_t;

    // Two serial steps at once: early is the first feedback bit, late the second.
    function automatic prbs_step_t prbs7_step2(input logic [6:0] s);
        prbs_step_t r;
        r.early = s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
        r.late  = s[PRBS7_TAP_HI-1] ^ s[PRBS7_TAP_LO-1];
        r.state = {s[4:0], r.early, r.late};
        return r;
    endfunction

    typedef struct packed {
        logic vld;
        logic prbs;
        logic rise;
        logic fall;
    } lb_tap_t;

endpackage

// File: rtl/prbs7_gen2.sv
// PRBS7 (x^7+x^6+1) source producing two bits per cycle, early bit first.
// Latency: bits are combinational from the register; load/adv act on the next edge.
// Backpressure: none; the register holds whenever adv is low.
module prbs7_gen2
    import oddr_pkg::*;
#(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic adv,
    output logic bit_early,
    output logic bit_late
);

    logic [6:0] lfsr_q;
    prbs_step_t step;

    assign step      = prbs7_step2(lfsr_q);
    assign bit_early = step.early;
    assign bit_late  = step.late;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (load) begin
            lfsr_q <= SEED;
        end else if (adv) begin
            lfsr_q <= step.state;
        end
    end

endmodule

// File: rtl/oddr_pattern_gen.sv
// ODDR bit-pair/oe sequencer: preamble, pattern run, postamble, release. Macro ODDR_PAT_LOOPBACK_CHK_EN adds IDDR checker.
// Latency: start sampled at edge t shows oe/busy after edge t+1; all outputs registered.
// Backpressure: none; start ignored unless IDLE with enable high, enable low forces POST.
module oddr_pattern_gen
    import oddr_pkg::*;
#(
    parameter int         PREAMBLE_CYC = 4,
    parameter int         BURST_W      = 16,
    parameter logic [6:0] PRBS_SEED    = 7'h7F
`ifdef ODDR_PAT_LOOPBACK_CHK_EN
    ,
    parameter int         LOOPBACK_LAT = 3
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [BURST_W-1:0] burst_len,
`ifdef ODDR_PAT_LOOPBACK_CHK_EN
    input  logic               q_rise,
    input  logic               q_fall,
    output logic [15:0]        err_cnt,
`endif
    output logic               d_rise,
    output logic               d_fall,
    output logic               oe,
    output logic               busy,
    output logic               done
);

    localparam int PRE_W = (PREAMBLE_CYC > 1) ? $clog2(PREAMBLE_CYC) : 1;

    gen_state_e         state_q, state_d;
    pat_mode_e          mode_q;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] run_cnt;
    logic [PRE_W-1:0]   pre_cnt;
    logic               tog_q;
    logic               pre_last, run_last, launch;
    logic               prbs_early, prbs_late;
    logic               oe_d, rise_d, fall_d, busy_d, done_d;

    assign pre_last = (pre_cnt == PRE_W'(PREAMBLE_CYC - 1));
    // burst_q is nonzero whenever this term matters, so the subtraction never wraps
    assign run_last = (burst_q != '0) && (run_cnt == (burst_q - BURST_W'(1)));
    assign launch   = (state_q == IDLE) && (state_d == PRE);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start && enable) state_d = PRE;
            PRE: begin
                if (!enable)       state_d = POST;
                else if (pre_last) state_d = RUN;
            end
            RUN:  if (!enable || run_last) state_d = POST;
            POST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- latched config, counters, toggle phase ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= CLOCK;
            burst_q <= '0;
            pre_cnt <= '0;
            run_cnt <= '0;
            tog_q   <= 1'b0;
        end else if (launch) begin
            mode_q  <= pat_mode_e'(mode);
            burst_q <= burst_len;
            pre_cnt <= '0;
            run_cnt <= '0;
            tog_q   <= 1'b0;
        end else begin
            if (state_q == PRE) pre_cnt <= pre_cnt + PRE_W'(1);
            if (state_q == RUN) begin
                run_cnt <= run_cnt + BURST_W'(1);
                tog_q   <= ~tog_q;
            end
        end
    end

    prbs7_gen2 #(.SEED(PRBS_SEED)) u_prbs_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (launch),
        .adv       ((state_q == RUN) && (mode_q == PRBS7)),
        .bit_early (prbs_early),
        .bit_late  (prbs_late)
    );

    // ---------------- output decode ----------------
    always_comb begin
        oe_d   = 1'b0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        unique case (state_q)
            PRE, POST: oe_d = 1'b1;
            RUN: begin
                oe_d = 1'b1;
                unique case (mode_q)
                    CLOCK:  rise_d = 1'b1;
                    TOGGLE: begin
                        rise_d = ~tog_q;
                        fall_d = ~tog_q;
                    end
                    PRBS7: begin
                        rise_d = prbs_early;
                        fall_d = prbs_late;
                    end
                    HOLD: begin
                        rise_d = 1'b1;
                        fall_d = 1'b1;
                    end
                    default: rise_d = 1'b0;
                endcase
            end
            default: oe_d = 1'b0;
        endcase
        busy_d = (state_q != IDLE);
        // IDLE while oe still shows POST only happens on the cycle right after POST
        done_d = (state_q == IDLE) && oe;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rise <= 1'b0;
            d_fall <= 1'b0;
            oe     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            d_rise <= rise_d;
            d_fall <= fall_d;
            oe     <= oe_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

`ifdef ODDR_PAT_LOOPBACK_CHK_EN
    logic        run_vld_q;
    lb_tap_t     pipe_q [LOOPBACK_LAT];
    lb_tap_t     tap;
    logic        chk_early, chk_late, exp_rise, exp_fall;
    logic [1:0]  mism;
    logic [16:0] err_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_vld_q <= 1'b0;
            for (int i = 0; i < LOOPBACK_LAT; i++) pipe_q[i] <= '0;
        end else begin
            run_vld_q <= (state_q == RUN);
            pipe_q[0] <= '{vld: run_vld_q, prbs: (mode_q == PRBS7), rise: d_rise, fall: d_fall};
            for (int i = 1; i < LOOPBACK_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tap = pipe_q[LOOPBACK_LAT-1];

    // Independent PRBS reference: reseeds whenever the delayed run window is closed.
    prbs7_gen2 #(.SEED(PRBS_SEED)) u_prbs_chk (
        .clk       (clk),
        .rst       (rst),
        .load      (!tap.vld),
        .adv       (tap.vld && tap.prbs),
        .bit_early (chk_early),
        .bit_late  (chk_late)
    );

    assign exp_rise = tap.prbs ? chk_early : tap.rise;
    assign exp_fall = tap.prbs ? chk_late  : tap.fall;
    assign mism     = 2'(q_rise != exp_rise) + 2'(q_fall != exp_fall);
    assign err_sum  = 17'(err_cnt) + 17'(mism);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (launch) begin
            err_cnt <= '0;
        end else if (tap.vld) begin
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_oddr_pattern_gen.sv
// Directed, table-driven bench for oddr_pattern_gen: per-cycle output windows plus corner sequences.
module tb_oddr_pattern_gen;
    import oddr_pkg::*;

    localparam int P = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] burst_len;
    logic        d_rise, d_fall, oe, busy, done;

    int errors = 0;
    int checks = 0;

`ifdef ODDR_PAT_LOOPBACK_CHK_EN
    logic        q_rise, q_fall;
    logic [15:0] err_cnt;
    logic [1:0]  hist [4] = '{default: 2'b00};
    bit          inj_en = 1'b0;
    int          inj_cnt = 0;

    // Loopback model: q replays the transmitted pair three cycles later.
    always @(negedge clk) begin
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = {d_rise, d_fall};
        q_rise  = hist[3][1];
        q_fall  = hist[3][0] ^ (inj_en && hist[3][1] && inj_cnt < 6);
        if (inj_en && hist[3][1] && inj_cnt < 6) inj_cnt++;
    end
`endif

    oddr_pattern_gen #(
        .PREAMBLE_CYC (P),
        .BURST_W      (16),
        .PRBS_SEED    (7'h7F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .start     (start),
        .mode      (mode),
        .burst_len (burst_len),
`ifdef ODDR_PAT_LOOPBACK_CHK_EN
        .q_rise    (q_rise),
        .q_fall    (q_fall),
        .err_cnt   (err_cnt),
`endif
        .d_rise    (d_rise),
        .d_fall    (d_fall),
        .oe        (oe),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] len;
        logic [15:0] exp_rise;   // bit i = expected d_rise in RUN cycle i
        logic [15:0] exp_fall;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {oe, busy, done, d_rise, d_fall};
    endfunction

    task automatic start_txn(input logic [1:0] m, input logic [15:0] len);
        @(negedge clk);
        mode = m; burst_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Applies one vector and checks {oe,busy,done,rise,fall} every cycle of the window.
    // Mode/length are scrambled after the start and start is re-pulsed in RUN and POST.
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        logic [4:0] exp;
        n = int'(v.len);
        start_txn(v.mode, v.len);
        mode = ~v.mode;
        burst_len = v.len + 16'd3;
        chk({tag, ".k1"}, outs(), 5'b00000);
        for (int k = 2; k <= n + P + 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k <= P + 1)          exp = 5'b11000;
            else if (k <= P + 1 + n) exp = {3'b110, v.exp_rise[k-P-2], v.exp_fall[k-P-2]};
            else if (k == P + n + 2) exp = 5'b11000;
            else if (k == P + n + 3) exp = 5'b00100;
            else                     exp = 5'b00000;
            chk($sformatf("%s.k%0d", tag, k), outs(), exp);
            if (k == P + 2 || k == P + n + 1) start = 1'b1;
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(name, seen, 1'b1);
    endtask

    initial begin
        int n_oe, n_hi;
        logic [4:0] exp;

        vecs[0] = '{2'd0, 16'd5, 16'h001F, 16'h0000};  // CLOCK
        vecs[1] = '{2'd2, 16'd4, 16'h0008, 16'h0000};  // PRBS7 from 7F: 00 00 00 10
        vecs[2] = '{2'd2, 16'd8, 16'h0048, 16'h0040};  // ... then 00 00 11 00
        vecs[3] = '{2'd1, 16'd6, 16'h0015, 16'h0015};  // TOGGLE 1,0,1,...
        vecs[4] = '{2'd3, 16'd3, 16'h0007, 16'h0007};  // HOLD
        vecs[5] = '{2'd0, 16'd1, 16'h0001, 16'h0000};  // single RUN cycle

        rst = 1'b1; enable = 1'b1; start = 1'b0; mode = 2'd0; burst_len = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 5'b00000);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", outs(), 5'b00000);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        run_vec(vecs[1], "prbs_repeat");

        // Continuous toggle, enable dropped after 20 RUN cycles
        start_txn(2'd1, 16'd0);
        for (int k = 2; k <= 28; k++) begin
            @(negedge clk);
            if (k <= P + 1)       exp = 5'b11000;
            else if (k <= P + 21) exp = {3'b110, ((k - 6) % 2 == 0), ((k - 6) % 2 == 0)};
            else if (k == P + 22) exp = 5'b11000;
            else if (k == P + 23) exp = 5'b00100;
            else                  exp = 5'b00000;
            chk($sformatf("cont_tog.k%0d", k), outs(), exp);
            if (k == 24) enable = 1'b0;
        end

        // start ignored while enable is low
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("start_no_en.c%0d", k), outs(), 5'b00000);
        end
        enable = 1'b1;

        // enable drop during preamble
        start_txn(2'd0, 16'd5);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            exp = (k <= 4) ? 5'b11000 : (k == 5) ? 5'b00100 : 5'b00000;
            chk($sformatf("pre_drop.k%0d", k), outs(), exp);
            if (k == 2) enable = 1'b0;
        end
        enable = 1'b1;

        // reset mid-RUN in HOLD: outputs clear asynchronously, no done
        start_txn(2'd3, 16'd10);
        repeat (7) @(negedge clk);
        chk("hold_mid_run", outs(), 5'b11011);
        #2 rst = 1'b1;
        #1 chk("rst_async", outs(), 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("after_rst.c%0d", k), outs(), 5'b00000);
        end
        run_vec(vecs[0], "restart");

        // maximum burst length must run to completion
        start_txn(2'd0, 16'hFFFF);
        n_oe = 0; n_hi = 0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (oe) n_oe++;
            if (d_rise) n_hi++;
            if (done) break;
        end
        chk("max_len_oe_cycles", n_oe, 65540);
        chk("max_len_run_cycles", n_hi, 65535);

`ifdef ODDR_PAT_LOOPBACK_CHK_EN
        repeat (4) @(negedge clk);
        start_txn(2'd0, 16'd10);
        wait_done("lb_clean_done");
        repeat (4) @(negedge clk);
        chk("lb_clean_err", err_cnt, 16'd0);
        inj_cnt = 0;
        inj_en  = 1'b1;
        start_txn(2'd0, 16'd10);
        wait_done("lb_inj_done");
        repeat (4) @(negedge clk);
        chk("lb_inj_err", err_cnt, 16'd6);
        inj_en = 1'b0;
        start_txn(2'd2, 16'd8);
        wait_done("lb_prbs_done");
        repeat (4) @(negedge clk);
        chk("lb_prbs_err", err_cnt, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oddr_pattern_gen.md
Name: oddr_pattern_gen

Overview:
- Upstream stage of the ODDR output wrapper. Generates the per-cycle rising-edge/falling-edge bit pair (d_rise, d_fall) and the output-enable for the bidirectional FPGA pin.
- Sequences one transmission as preamble → pattern run → postamble → release.
- Selectable patterns: forwarded clock, half-rate toggle, PRBS7, static high.
- Driven by the VIO enable and start controls in the 100 MHz domain.

Parameters:
- PREAMBLE_CYC, 4: cycles of driven-low preamble before the pattern; legal range ≥1.
- BURST_W, 16: width of burst_len.
- PRBS_SEED, 7'h7F: PRBS7 seed; must be nonzero.

Ports:
- clk  in  1  fabric clock (100 MHz from clock wizard).
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  master enable (VIO); level-sensitive.
- start  in  1  single-cycle start request.
- mode  in  2  pattern select: 0 CLOCK, 1 TOGGLE, 2 PRBS7, 3 HOLD.
- burst_len  in  BURST_W  run length in cycles; 0 = continuous.
- d_rise  out  1  bit driven on the rising edge (ODDR D1).
- d_fall  out  1  bit driven on the falling edge (ODDR D2).
- oe  out  1  pin output enable; 1 = drive, 0 = tristate.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse when a transmission ends.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, d_rise=0, d_fall=0, oe=0, busy=0, done=0, prbs=PRBS_SEED, counters 0.
- All outputs are registered. start sampled high at edge t gives oe=1 and busy=1 after edge t+1.
- IDLE:
  - start=1 with enable=1 → PRE. mode and burst_len are latched; PRBS is reseeded.
  - start is ignored when enable=0.
  - start is ignored when not in IDLE (including during POST).
- PRE:
  - oe=1, d_rise=d_fall=0 for exactly PREAMBLE_CYC cycles, then RUN.
- RUN (pattern per latched mode):
  - CLOCK: d_rise=1, d_fall=0 every cycle.
  - TOGGLE: d_rise=d_fall; the value alternates each cycle, starting at 1.
  - PRBS7: polynomial x^7+x^6+1, advanced 2 bits per cycle. d_rise takes the earlier bit, d_fall the later bit.
  - HOLD: d_rise=d_fall=1.
  - burst_len=N>0: exactly N RUN cycles, then POST.
  - burst_len=0: RUN continues until enable=0.
- Enable drop: enable=0 sampled in PRE or RUN → POST on the next edge, cutting the run short.
- POST:
  - One cycle with oe=1, d_rise=d_fall=0.
  - Next edge: oe=0, done=1 for one cycle, state=IDLE, busy=0.
- Mode and burst_len changes mid-transmission have no effect until the next start.
- Counter wrap: maximum burst_len (2^BURST_W−1) is legal. The run counter must not wrap early.
- Reset asserted mid-transmission: all outputs go immediately to reset values; oe releases asynchronously. No done pulse is issued.

Optional Feature:
- Macro: ODDR_PAT_LOOPBACK_CHK_EN.
- When defined:
  - Adds inputs q_rise and q_fall (from an IDDR on the same pin).
  - Adds parameter LOOPBACK_LAT, default 3.
  - Adds output err_cnt[15:0].
  - During RUN, each received bit is compared against the transmitted pair delayed by LOOPBACK_LAT cycles. Comparison is gated by a valid bit that is delayed the same way.
  - err_cnt increments by the number of mismatching bits (0–2) per cycle and saturates at 16'hFFFF.
  - err_cnt clears on the IDLE→PRE transition.
- When undefined: these ports, the parameter and the logic are absent, with no other change.

Decomposition:
- Shared package oddr_pkg holds:
  - typedef enum pat_mode_e {CLOCK, TOGGLE, PRBS7, HOLD};
  - typedef enum gen_state_e {IDLE, PRE, RUN, POST};
  - the PRBS7 tap constants.
- One sub-module: prbs7_gen2. It takes a seed load and an advance strobe and outputs 2 bits per cycle. The loopback checker reuses it.

Test Plan:
- Reset, then start with mode=0, burst_len=5, PREAMBLE_CYC=4 → oe high for 10 cycles (4 PRE + 5 RUN + 1 POST); d_rise/d_fall = (1,0) ×5; done pulses once; busy is low afterwards.
- mode=2, burst_len=4, seed 7'h7F → 8 output bits match the reference PRBS7 sequence from 7'h7F, rise bit first; a second start repeats the identical sequence.
- mode=1, burst_len=0, enable dropped after 20 RUN cycles → one POST cycle, then oe=0 and done=1; the toggle alternated 1,0,1,… throughout.
- start asserted with enable=0, and start asserted during RUN/POST → no state change, no extra done pulse.
- rst asserted mid-RUN with mode=3 → oe=0, d_rise=d_fall=0 immediately; no done; the next start behaves normally.
- With ODDR_PAT_LOOPBACK_CHK_EN and q tied to d delayed by 3 cycles → err_cnt=0. Forcing q_fall inverted for 6 RUN cycles → err_cnt=6.
